// File: rtl/jtag_ahb_pkg.sv
// Shared widths and payload types for the JTAG-to-AHB debug data registers.
package jtag_ahb_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SEQ_W   = 4;
   localparam int unsigned FRAME_W = DATA_W + SEQ_W + 2;

   typedef enum logic [1:0] {
      ST_NONE = 2'b00,
      ST_OK   = 2'b01,
      ST_ERR  = 2'b10,
      ST_BUSY = 2'b11
   } resp_status_t;

   typedef logic [0:0] hs_state_t;
   localparam hs_state_t WAIT_REQ  = 1'b0;
   localparam hs_state_t WAIT_DROP = 1'b1;

   typedef struct packed {
      resp_status_t       status;
      logic [SEQ_W-1:0]   seq;
      logic [DATA_W-1:0]  data;
   } resp_frame_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single-bit asynchronous input, with a
// synchronous clear for soft resets.
module sync_ff #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   ff <= '0;
      else if (clr) ff <= '0;
      else          ff <= SYNC_STAGES'({ff, d});
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_ahb_resp_dr.sv
// TCK-domain data register holding one AHB response (data, error, sequence)
// and scanning it out to the debugger as a 38-bit frame.
module jtag_ahb_resp_dr
   import jtag_ahb_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              TCK,
   input  logic              TRST,
   input  logic              soft_reset,
   input  logic              ahb_select,
   input  logic              dr_capture,
   input  logic              dr_shift,
   input  logic              dr_update,
   input  logic              TDI,
   output logic              TDO,
   input  logic              resp_req,
   input  logic [DATA_W-1:0] resp_rdata,
   input  logic              resp_error,
   output logic              resp_ack,
   output logic              resp_pending
);

   hs_state_t          state_q, state_d;
   logic [FRAME_W-1:0] shift_q, shift_d;
   logic [DATA_W-1:0]  hold_data_q, hold_data_d;
   logic               hold_err_q, hold_err_d;
   logic [SEQ_W-1:0]   seq_q, seq_d;
   logic               pending_q, pending_d;
   logic               cap_valid_q, cap_valid_d;
   logic               ack_q, ack_d;
   logic               req_s;
   resp_frame_t        frame;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
      .clk   (TCK),
      .rst_n (TRST),
      .clr   (soft_reset),
      .d     (resp_req),
      .q     (req_s)
   );

   // Busy only counts a request the handshake has not yet accepted.
   always_comb begin
      frame      = '0;
      frame.seq  = seq_q;
      if (pending_q) begin
         frame.data   = hold_data_q;
         frame.status = (req_s && state_q == WAIT_REQ) ? ST_BUSY
                      : hold_err_q                     ? ST_ERR
                      :                                  ST_OK;
      end else begin
         frame.status = ST_NONE;
      end
   end

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      hold_data_d = hold_data_q;
      hold_err_d  = hold_err_q;
      seq_d       = seq_q;
      pending_d   = pending_q;
      cap_valid_d = cap_valid_q;
      ack_d       = ack_q;

      case (state_q)
         WAIT_REQ: begin
            if (req_s && !pending_q) begin
               hold_data_d = resp_rdata;
               hold_err_d  = resp_error;
               pending_d   = 1'b1;
               seq_d       = seq_q + SEQ_W'(1);
               ack_d       = 1'b1;
               state_d     = WAIT_DROP;
            end
         end
         WAIT_DROP: begin
            if (!req_s) begin
               ack_d   = 1'b0;
               state_d = WAIT_REQ;
            end
         end
         default: state_d = WAIT_REQ;
      endcase

      // Consume only needs pending=1 (cap_valid implies it), so it never collides with a latch.
      if (ahb_select) begin
         if (dr_capture) begin
            shift_d     = frame;
            cap_valid_d = pending_q;
         end else if (dr_shift) begin
            shift_d = {TDI, shift_q[FRAME_W-1:1]};
         end else if (dr_update && cap_valid_q) begin
            pending_d   = 1'b0;
            cap_valid_d = 1'b0;
         end
      end

      if (soft_reset) begin
         state_d     = WAIT_REQ;
         shift_d     = '0;
         hold_data_d = '0;
         hold_err_d  = 1'b0;
         seq_d       = '0;
         pending_d   = 1'b0;
         cap_valid_d = 1'b0;
         ack_d       = 1'b0;
      end
   end

   always_ff @(posedge TCK or negedge TRST) begin
      if (!TRST) begin
         state_q     <= WAIT_REQ;
         shift_q     <= '0;
         hold_data_q <= '0;
         hold_err_q  <= 1'b0;
         seq_q       <= '0;
         pending_q   <= 1'b0;
         cap_valid_q <= 1'b0;
         ack_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         hold_data_q <= hold_data_d;
         hold_err_q  <= hold_err_d;
         seq_q       <= seq_d;
         pending_q   <= pending_d;
         cap_valid_q <= cap_valid_d;
         ack_q       <= ack_d;
      end
   end

   assign TDO          = shift_q[0];
   assign resp_ack     = ack_q;
   assign resp_pending = pending_q;

endmodule

// File: tb/tb_jtag_ahb_resp_dr.sv
// Directed bench for jtag_ahb_resp_dr: behavioural response model checked every
// cycle, plus hand-computed frame and handshake expectations.
module tb_jtag_ahb_resp_dr;

   localparam int unsigned FW = 38;

   logic        TCK = 1'b0;
   logic        TRST = 1'b0;
   logic        soft_reset = 1'b0;
   logic        ahb_select = 1'b0;
   logic        dr_capture = 1'b0;
   logic        dr_shift = 1'b0;
   logic        dr_update = 1'b0;
   logic        TDI = 1'b0;
   logic        TDO;
   logic        resp_req = 1'b0;
   logic [31:0] resp_rdata = '0;
   logic        resp_error = 1'b0;
   logic        resp_ack;
   logic        resp_pending;

   int vectors = 0;
   int miscompares = 0;

   always #5 TCK = ~TCK;

   jtag_ahb_resp_dr #(.SYNC_STAGES(2)) dut (
      .TCK          (TCK),
      .TRST         (TRST),
      .soft_reset   (soft_reset),
      .ahb_select   (ahb_select),
      .dr_capture   (dr_capture),
      .dr_shift     (dr_shift),
      .dr_update    (dr_update),
      .TDI          (TDI),
      .TDO          (TDO),
      .resp_req     (resp_req),
      .resp_rdata   (resp_rdata),
      .resp_error   (resp_error),
      .resp_ack     (resp_ack),
      .resp_pending (resp_pending)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: the debugger-visible state of one response slot.
   logic [FW-1:0] m_sr;
   logic [31:0]   m_data;
   logic [3:0]    m_seq;
   logic          m_pend, m_err, m_capv, m_ack;
   logic [1:0]    m_hist;

   always @(posedge TCK or negedge TRST) begin
      logic          req_seen, busy, p0, c0, a0;
      logic [1:0]    st;
      logic [FW-1:0] frame;
      if (!TRST || soft_reset) begin
         m_sr = '0; m_data = '0; m_seq = '0;
         m_pend = 1'b0; m_err = 1'b0; m_capv = 1'b0; m_ack = 1'b0; m_hist = '0;
      end else begin
         req_seen = m_hist[1];
         p0 = m_pend; c0 = m_capv; a0 = m_ack;
         busy = p0 && req_seen && !a0;
         if (!p0)       st = 2'b00;
         else if (busy) st = 2'b11;
         else if (m_err) st = 2'b10;
         else           st = 2'b01;
         frame = {st, m_seq, (p0 ? m_data : 32'h0)};
         m_hist = {m_hist[0], resp_req};
         if (!a0 && req_seen && !p0) begin
            m_data = resp_rdata; m_err = resp_error; m_pend = 1'b1;
            m_seq = m_seq + 4'd1; m_ack = 1'b1;
         end else if (a0 && !req_seen) begin
            m_ack = 1'b0;
         end
         if (ahb_select) begin
            if (dr_capture) begin
               m_sr = frame; m_capv = p0;
            end else if (dr_shift) begin
               m_sr = {TDI, m_sr[FW-1:1]};
            end else if (dr_update && c0) begin
               m_pend = 1'b0; m_capv = 1'b0;
            end
         end
      end
   end

   always @(negedge TCK) begin
      chk("tdo", 64'(TDO), 64'(m_sr[0]));
      chk("resp_ack", 64'(resp_ack), 64'(m_ack));
      chk("resp_pending", 64'(resp_pending), 64'(m_pend));
   end

   task automatic scan(output logic [FW-1:0] got);
      ahb_select = 1'b1; dr_capture = 1'b1;
      @(negedge TCK);
      dr_capture = 1'b0; dr_shift = 1'b1;
      TDI = 1'b0;
      for (int i = 0; i < int'(FW); i++) begin
         got[i] = TDO;
         @(negedge TCK);
      end
      dr_shift = 1'b0;
   endtask

   task automatic update(input logic sel);
      ahb_select = sel; dr_update = 1'b1;
      @(negedge TCK);
      dr_update = 1'b0; ahb_select = 1'b1;
   endtask

   task automatic send(input logic [31:0] d, input logic e);
      resp_rdata = d; resp_error = e; resp_req = 1'b1;
   endtask

   task automatic wait_ack(input logic v, input int budget, input string name);
      int n = 0;
      while (resp_ack !== v && n < budget) begin
         @(negedge TCK);
         n++;
      end
      chk(name, 64'(resp_ack), 64'(v));
   endtask

   task automatic handshake(input logic [31:0] d, input logic e);
      send(d, e);
      wait_ack(1'b1, 4, "ack_rise");
      resp_req = 1'b0;
      wait_ack(1'b0, 4, "ack_fall");
   endtask

   logic [FW-1:0] got;

   initial begin
      repeat (3) @(negedge TCK);
      chk("reset_ack", 64'(resp_ack), 64'd0);
      chk("reset_tdo", 64'(TDO), 64'd0);
      TRST = 1'b1;
      @(negedge TCK);

      // Idle scan
      scan(got);
      chk("idle_frame", 64'(got), 64'h0);
      update(1'b1);

      // Single OK read with exact ack latency
      send(32'hDEADBEEF, 1'b0);
      repeat (2) @(negedge TCK);
      chk("ack_lat2", 64'(resp_ack), 64'd0);
      @(negedge TCK);
      chk("ack_lat3", 64'(resp_ack), 64'd1);
      resp_req = 1'b0;
      wait_ack(1'b0, 3, "ack_drop");
      scan(got);
      chk("ok_frame", 64'(got), 64'({2'b01, 4'h1, 32'hDEADBEEF}));
      update(1'b1);
      chk("ok_consumed", 64'(resp_pending), 64'd0);

      // Error response
      handshake(32'h0, 1'b1);
      scan(got);
      chk("err_frame", 64'(got), 64'({2'b10, 4'h2, 32'h0}));
      update(1'b1);
      chk("err_consumed", 64'(resp_pending), 64'd0);

      // Backpressure
      handshake(32'h12345678, 1'b0);
      send(32'hCAFEF00D, 1'b0);
      repeat (6) @(negedge TCK);
      chk("bp_no_ack", 64'(resp_ack), 64'd0);
      scan(got);
      chk("bp_frame", 64'(got), 64'({2'b11, 4'h3, 32'h12345678}));
      update(1'b1);
      wait_ack(1'b1, 3, "bp_ack_after_update");
      resp_req = 1'b0;
      wait_ack(1'b0, 4, "bp_ack_fall");
      scan(got);
      chk("bp_second_frame", 64'(got), 64'({2'b01, 4'h4, 32'hCAFEF00D}));
      update(1'b1);

      // Late arrival between capture and update
      send(32'hA5A50001, 1'b0);
      @(negedge TCK);
      scan(got);
      chk("late_first_frame", 64'(got), 64'({2'b00, 4'h4, 32'h0}));
      resp_req = 1'b0;
      wait_ack(1'b0, 4, "late_ack_fall");
      update(1'b1);
      chk("late_not_consumed", 64'(resp_pending), 64'd1);
      scan(got);
      chk("late_second_frame", 64'(got), 64'({2'b01, 4'h5, 32'hA5A50001}));
      update(1'b1);
      chk("late_consumed", 64'(resp_pending), 64'd0);

      // Update while the register is deselected
      handshake(32'h0F0F0F0F, 1'b1);
      scan(got);
      chk("desel_frame", 64'(got), 64'({2'b10, 4'h6, 32'h0F0F0F0F}));
      update(1'b0);
      chk("desel_no_consume", 64'(resp_pending), 64'd1);
      update(1'b1);
      chk("sel_consume", 64'(resp_pending), 64'd0);

      // Soft reset mid-handshake
      send(32'h00000055, 1'b0);
      wait_ack(1'b1, 4, "sr_ack_rise");
      soft_reset = 1'b1;
      @(negedge TCK);
      chk("sr_ack", 64'(resp_ack), 64'd0);
      chk("sr_pending", 64'(resp_pending), 64'd0);
      soft_reset = 1'b0; resp_req = 1'b0;
      repeat (3) @(negedge TCK);
      scan(got);
      chk("sr_frame", 64'(got), 64'h0);
      update(1'b1);

      // TRST mid-handshake drops ack without a clock edge
      send(32'h00000077, 1'b1);
      wait_ack(1'b1, 4, "trst_ack_rise");
      #2 TRST = 1'b0;
      #1;
      chk("trst_ack", 64'(resp_ack), 64'd0);
      chk("trst_pending", 64'(resp_pending), 64'd0);
      @(negedge TCK);
      resp_req = 1'b0; TRST = 1'b1;
      repeat (3) @(negedge TCK);
      scan(got);
      chk("trst_frame", 64'(got), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/jtag_ahb_resp_dr.md
Name: jtag_ahb_resp_dr

Overview:
- TCK-domain JTAG data register that returns AHB transaction results to the debugger.
- Accepts a response (read data plus error flag) from the AHB-side bridge over a 4-phase req/ack handshake and holds it.
- Presents the held response as a 38-bit frame in Capture-DR and shifts it out on TDO in Shift-DR.
- Companion of the AHB command register, which shifts requests in the opposite direction.

Parameters:
- DATA_W, 32, width of the AHB read-data field.
- SEQ_W, 4, width of the response sequence counter.
- SYNC_STAGES, 2, flop stages synchronising resp_req into TCK.
- Derived: FRAME_W = DATA_W + SEQ_W + 2 = 38.

Ports:
- TCK  in  1  JTAG test clock.
- TRST  in  1  reset, asynchronous, active-low.
- soft_reset  in  1  synchronous clear, same effect as TRST.
- ahb_select  in  1  IR selects the AHB data register.
- dr_capture  in  1  TAP in Capture-DR.
- dr_shift  in  1  TAP in Shift-DR.
- dr_update  in  1  TAP in Update-DR.
- TDI  in  1  serial input.
- TDO  out  1  serial output, equal to shift_reg[0].
- resp_req  in  1  AHB-side request, asynchronous to TCK.
- resp_rdata  in  DATA_W  read data, stable while resp_req is high.
- resp_error  in  1  HRESP error flag, stable while resp_req is high.
- resp_ack  out  1  acknowledge to the AHB side.
- resp_pending  out  1  holding register is full.

Behaviour:
- Reset (TRST low or soft_reset high):
  - shift_reg, hold_data, hold_err, seq, pending, resp_ack all cleared to 0.
  - FSM goes to WAIT_REQ; synchroniser flops cleared.
  - TDO = 0.
- Synchroniser: req_s is resp_req after SYNC_STAGES TCK flops.
- Handshake FSM:
  - WAIT_REQ: if req_s=1 and pending=0, go to WAIT_DROP on the same edge and:
    - hold_data <= resp_rdata; hold_err <= resp_error;
    - pending <= 1; seq <= seq+1 (wraps 15 to 0);
    - resp_ack <= 1.
    - If req_s=1 and pending=1, stay in WAIT_REQ: backpressure, busy condition.
  - WAIT_DROP: when req_s=0, resp_ack <= 0 and go to WAIT_REQ.
  - Latency: from resp_req rise to resp_ack high is SYNC_STAGES+1 TCK edges when pending=0.
- Frame layout:
  - [37:36] status:
    - 00 = no response;
    - 01 = pending OK;
    - 10 = pending error;
    - 11 = pending and another req_s=1 waiting (busy/overrun warning).
  - [35:32] seq.
  - [31:0] hold_data, or 0 when not pending.
- DR operations (only when ahb_select=1; otherwise shift_reg is held):
  - dr_capture: shift_reg <= frame; cap_valid <= pending.
  - dr_shift: shift_reg <= {TDI, shift_reg[FRAME_W-1:1]}, LSB out first.
  - dr_update: if cap_valid=1, pending <= 0 and cap_valid <= 0 (response consumed). If cap_valid=0, no effect.
  - Priority: capture > shift > update. Only one is asserted at a time in a legal TAP; priority applies on illegal overlap.
- Boundary rules:
  - Consume and latch are mutually exclusive: latch needs pending=0, consume needs pending=1.
  - A response latched after Capture-DR is not consumed by the following Update-DR, because cap_valid was 0. It appears on the next scan.
  - Update with ahb_select=0: no consume.
  - TRST or soft_reset mid-handshake: resp_ack drops immediately (TRST) or on the next edge (soft_reset). The held response is lost. The AHB side must tolerate an ack withdrawn before its req falls.
  - resp_req glitches shorter than SYNC_STAGES cycles may be missed; the AHB side holds req until it sees ack.

Decomposition:
- Package jtag_ahb_pkg:
  - DATA_W, SEQ_W, FRAME_W;
  - typedef resp_status_t (ST_NONE=2'b00, ST_OK=2'b01, ST_ERR=2'b10, ST_BUSY=2'b11);
  - typedef hs_state_t (WAIT_REQ, WAIT_DROP);
  - packed struct resp_frame_t {status, seq, data}.
- Sub-module: sync_ff (parameterised SYNC_STAGES, async active-low reset), reused for other CDC inputs.

Test Plan:
- Reset idle: TRST low then high, capture and shift 38 bits with ahb_select=1 -> TDO stream all 0 (status 00, seq 0); resp_ack=0.
- Single OK read:
  - Stimulus: resp_req=1 with rdata=0xDEADBEEF, error=0.
  - Response: resp_ack=1 exactly 3 TCK later; drop req -> ack=0 within 3 TCK.
  - Scan -> LSB-first frame 0x1_1_DEADBEEF (status 01, seq 1); after update resp_pending=0.
- Error response: rdata=0x00000000, error=1 -> scanned status 10, seq 2; update clears pending.
- Backpressure:
  - Stimulus: latch 0x12345678, then raise a second req with 0xCAFEF00D before scanning.
  - Response: no ack; scan shows status 11, data 0x12345678.
  - After update: second req acked, next scan shows 0xCAFEF00D, seq +1.
- Late arrival: response latched between Capture-DR and Update-DR -> update does not clear pending; next scan returns it.
- Mid-handshake reset: assert soft_reset while resp_ack=1 -> ack=0, pending=0, seq=0 on the next edge; scan shows status 00.
